// File: rtl/vending_pkg.sv
// Shared vending definitions: coin values, nickel-unit constants, payout FSM states.
package vending_pkg;

  // Coin face values in cents, shared with the vend controller.
  localparam int unsigned NICKEL_CENTS = 5;
  localparam int unsigned DIME_CENTS   = 10;

  // Coin values in the nickel base unit used by all amount/remaining buses.
  localparam int unsigned NICKEL_UNITS = NICKEL_CENTS / NICKEL_CENTS;
  localparam int unsigned DIME_UNITS   = DIME_CENTS / NICKEL_CENTS;

  // Payout FSM states; encoding 3'b111 is unused and recovers to IDLE.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECIDE = 3'd1,
    S_DIME   = 3'd2,
    S_NICKEL = 3'd3,
    S_GAP    = 3'd4,
    S_DONE   = 3'd5,
    S_ERROR  = 3'd6
  } payout_state_e;

endpackage

// File: rtl/pulse_gap_timer.sv
// Loadable down-counter that enforces the mechanical gap after each coin pulse.
module pulse_gap_timer #(
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned CNT_W      = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic run_i,
  output logic expired_o
);

  // Loaded with GAP_CYCLES-1 so expiry lands on the last of GAP_CYCLES gap cycles.
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(GAP_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: reload on a coin cycle, count down while the gap runs.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (run_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Counter register, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = run_i && (cnt_q == '0);

endmodule

// File: rtl/coin_change_dispenser.sv
// Coin hopper payout controller: greedy dime-first change with per-coin gap.
module coin_change_dispenser
  import vending_pkg::*;
#(
  parameter int unsigned AMT_W      = 4,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [AMT_W-1:0] amount,
  input  logic             dime_empty,
  input  logic             nickel_empty,
  output logic             dime_out,
  output logic             nickel_out,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [AMT_W-1:0] remaining
);

  localparam logic [AMT_W-1:0] DIME_AMT   = AMT_W'(DIME_UNITS);
  localparam logic [AMT_W-1:0] NICKEL_AMT = AMT_W'(NICKEL_UNITS);

  payout_state_e    state_q, state_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic             gap_load, gap_run, gap_expired;

  assign gap_load = (state_q == S_DIME) || (state_q == S_NICKEL);
  assign gap_run  = (state_q == S_GAP);

  pulse_gap_timer #(
    .GAP_CYCLES (GAP_CYCLES),
    .CNT_W      (4)
  ) u_gap_timer (
    .clk       (clk),
    .reset     (reset),
    .load_i    (gap_load),
    .run_i     (gap_run),
    .expired_o (gap_expired)
  );

  // Next-state and remaining-amount logic.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (amount != '0) begin
            rem_d   = amount;
            state_d = S_DECIDE;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DECIDE: begin
        if ((rem_q >= DIME_AMT) && !dime_empty) begin
          state_d = S_DIME;
        end else if (!nickel_empty) begin
          state_d = S_NICKEL;
        end else begin
          state_d = S_ERROR;
        end
      end
      S_DIME: begin
        rem_d   = (rem_q >= DIME_AMT) ? (rem_q - DIME_AMT) : '0;
        state_d = S_GAP;
      end
      S_NICKEL: begin
        rem_d   = (rem_q >= NICKEL_AMT) ? (rem_q - NICKEL_AMT) : '0;
        state_d = S_GAP;
      end
      S_GAP: begin
        if (gap_expired) begin
          state_d = (rem_q == '0) ? S_DONE : S_DECIDE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_ERROR: begin
        if (start) begin
          state_d = S_DECIDE;
        end
      end
      default: begin
        state_d = S_IDLE;
        rem_d   = '0;
      end
    endcase
  end

  // State and remaining registers, cleared asynchronously so reset aborts a payout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  // Moore output decode from the current state only.
  always_comb begin
    dime_out   = 1'b0;
    nickel_out = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    unique case (state_q)
      S_IDLE:   ;
      S_DECIDE: busy = 1'b1;
      S_DIME: begin
        busy     = 1'b1;
        dime_out = 1'b1;
      end
      S_NICKEL: begin
        busy       = 1'b1;
        nickel_out = 1'b1;
      end
      S_GAP:    busy = 1'b1;
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      S_ERROR: begin
        busy  = 1'b1;
        error = 1'b1;
      end
      default:  ;
    endcase
  end

  assign remaining = rem_q;

endmodule

// File: tb/tb_coin_change_dispenser.sv
// Scoreboard bench for coin_change_dispenser: expected events queued at stimulus, popped by monitor.
module tb_coin_change_dispenser;

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] amount;
  logic       dime_empty;
  logic       nickel_empty;
  logic       dime_out;
  logic       nickel_out;
  logic       busy;
  logic       done;
  logic       error;
  logic [3:0] remaining;

  coin_change_dispenser #(
    .AMT_W      (4),
    .GAP_CYCLES (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .amount       (amount),
    .dime_empty   (dime_empty),
    .nickel_empty (nickel_empty),
    .dime_out     (dime_out),
    .nickel_out   (nickel_out),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .remaining    (remaining)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count of rising edges so far; during cycle k after the start edge e0, cyc == e0 + k - 1.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {EV_ERR, EV_DIME, EV_NICKEL, EV_DONE, EV_IDLE} ev_e;
  typedef struct {
    ev_e kind;
    int  cyc;
    int  rem;
  } ev_t;

  ev_t  exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic prev_busy;
  logic prev_err;

  task automatic expect_ev(input ev_e k, input int e0, input int c, input int rem);
    ev_t e;
    e.kind = k;
    e.cyc  = e0 + c - 1;
    e.rem  = rem;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic observe(input ev_e k);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_%s at cyc=%0d rem=%0d (nothing expected)", k.name(), cyc, remaining);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.cyc != cyc || e.rem != int'(remaining)) begin
        errors++;
        $display("FAIL event got %s@%0d rem=%0d want %s@%0d rem=%0d",
                 k.name(), cyc, remaining, e.kind.name(), e.cyc, e.rem);
      end
    end
    if (k == EV_DONE) begin
      chk("done_busy_high", int'(busy), 1);
      chk("done_error_low", int'(error), 0);
    end
  endtask

  // Monitor: turn DUT output activity into events and score them against the queue.
  initial begin : monitor
    prev_busy = 1'b0;
    prev_err  = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_busy = 1'b0;
        prev_err  = 1'b0;
      end else begin
        if (dime_out && nickel_out) begin
          checks++;
          errors++;
          $display("FAIL both_coins at cyc=%0d got dime=1 nickel=1 want at most one", cyc);
        end
        if (error && !prev_err) observe(EV_ERR);
        if (dime_out)           observe(EV_DIME);
        if (nickel_out)         observe(EV_NICKEL);
        if (done)               observe(EV_DONE);
        if (!busy && prev_busy) observe(EV_IDLE);
        prev_busy = busy;
        prev_err  = error;
      end
    end
  end

  // Raise start at a falling edge; e0 is the edge index that will sample it.
  task automatic issue(input logic [3:0] amt, input logic de, input logic ne, output int e0);
    @(negedge clk);
    amount       = amt;
    dime_empty   = de;
    nickel_empty = ne;
    start        = 1'b1;
    e0           = cyc + 1;
  endtask

  task automatic release_start();
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout pending=%0d want 0 after %0d cycles", exp_q.size(), budget);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int e0;
    reset        = 1'b1;
    start        = 1'b0;
    amount       = '0;
    dime_empty   = 1'b0;
    nickel_empty = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_error", int'(error), 0);
    chk("rst_dime", int'(dime_out), 0);
    chk("rst_nickel", int'(nickel_out), 0);
    chk("rst_remaining", int'(remaining), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // amount=3, tubes full: dime, then nickel, then done.
    issue(4'd3, 1'b0, 1'b0, e0);
    expect_ev(EV_DIME,   e0, 2,  3);
    expect_ev(EV_NICKEL, e0, 6,  1);
    expect_ev(EV_DONE,   e0, 9,  0);
    expect_ev(EV_IDLE,   e0, 10, 0);
    release_start();
    drain(40);

    // amount=4, dime tube empty: four nickels.
    issue(4'd4, 1'b1, 1'b0, e0);
    expect_ev(EV_NICKEL, e0, 2,  4);
    expect_ev(EV_NICKEL, e0, 6,  3);
    expect_ev(EV_NICKEL, e0, 10, 2);
    expect_ev(EV_NICKEL, e0, 14, 1);
    expect_ev(EV_DONE,   e0, 17, 0);
    expect_ev(EV_IDLE,   e0, 18, 0);
    release_start();
    drain(60);

    // amount=0: straight to done, no coins.
    issue(4'd0, 1'b0, 1'b0, e0);
    expect_ev(EV_DONE, e0, 1, 0);
    expect_ev(EV_IDLE, e0, 2, 0);
    release_start();
    drain(20);

    // amount=1 with dime tube full still pays a single nickel.
    issue(4'd1, 1'b0, 1'b0, e0);
    expect_ev(EV_NICKEL, e0, 2, 1);
    expect_ev(EV_DONE,   e0, 5, 0);
    expect_ev(EV_IDLE,   e0, 6, 0);
    release_start();
    drain(30);

    // amount=2, both tubes empty: error, then retry after nickel refill.
    issue(4'd2, 1'b1, 1'b1, e0);
    expect_ev(EV_ERR, e0, 2, 2);
    release_start();
    drain(20);
    repeat (3) @(negedge clk);
    chk("err_error_high", int'(error), 1);
    chk("err_busy_high", int'(busy), 1);
    chk("err_remaining_held", int'(remaining), 2);
    issue(4'd9, 1'b1, 1'b0, e0);
    expect_ev(EV_NICKEL, e0, 2,  2);
    expect_ev(EV_NICKEL, e0, 6,  1);
    expect_ev(EV_DONE,   e0, 9,  0);
    expect_ev(EV_IDLE,   e0, 10, 0);
    release_start();
    drain(40);

    // amount=5; start with amount=7 during GAP must be ignored.
    issue(4'd5, 1'b0, 1'b0, e0);
    expect_ev(EV_DIME,   e0, 2,  5);
    expect_ev(EV_DIME,   e0, 6,  3);
    expect_ev(EV_NICKEL, e0, 10, 1);
    expect_ev(EV_DONE,   e0, 13, 0);
    expect_ev(EV_IDLE,   e0, 14, 0);
    release_start();
    @(negedge clk);
    @(negedge clk);
    amount = 4'd7;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    drain(60);

    // Reset asserted mid-GAP with remaining=2 aborts the payout at once.
    issue(4'd4, 1'b0, 1'b0, e0);
    expect_ev(EV_DIME, e0, 2, 4);
    release_start();
    @(negedge clk);
    @(negedge clk);
    chk("gap_remaining_before_reset", int'(remaining), 2);
    #2 reset = 1'b1;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_remaining", int'(remaining), 0);
    chk("abort_dime", int'(dime_out), 0);
    chk("abort_nickel", int'(nickel_out), 0);
    chk("abort_done", int'(done), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (16) @(negedge clk);
    chk("post_abort_busy", int'(busy), 0);
    chk("post_abort_remaining", int'(remaining), 0);
    chk("post_abort_pending", exp_q.size(), 0);

    // Recovery after abort.
    issue(4'd2, 1'b0, 1'b0, e0);
    expect_ev(EV_DIME, e0, 2, 2);
    expect_ev(EV_DONE, e0, 5, 0);
    expect_ev(EV_IDLE, e0, 6, 0);
    release_start();
    drain(30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
